compar_minmax_seq: RTL and testbench
====================================

// Module: compar_minmax_seq
// PURPOSE
//  Sequencer around the shared 3-bit magnitude comparator compar3bit (y1=a>b, y2=a==b, y3=a<b).
//  Accepts a burst of 3-bit samples over valid/ready and time-multiplexes one comparator instance
//  to track the running maximum and minimum with their positions.
//  Presents one result per burst to a downstream consumer over valid/ready.
// PARAMETERS
//  DEPTH   8   max samples per burst (>=2); IW=$clog2(DEPTH), CW=$clog2(DEPTH+1)
// PORTS
//  clk        in   1    single clock, all logic on posedge
//  rst        in   1    synchronous, active-high reset
//  in_valid   in   1    sample offered
//  in_ready   out  1    block accepts sample this cycle
//  in_data    in   3    sample value (unsigned)
//  in_last    in   1    final sample of burst, qualified by in_valid&in_ready
//  out_valid  out  1    result available
//  out_ready  in   1    consumer takes result
//  max_val    out  3    largest sample of burst
//  min_val    out  3    smallest sample of burst
//  max_idx    out  IW   position (0-based) of first occurrence of max
//  min_idx    out  IW   position of first occurrence of min
//  count      out  CW   samples accepted in burst
//  eq_all     out  1    all samples equal (max_val==min_val)
//  ovf        out  1    burst terminated by DEPTH limit, not in_last
// BEHAVIOUR
//  - Reset: state=ACCEPT; in_ready=1; out_valid=0; max/min/idx/count/eq_all/ovf=0; hold reg=0.
//  - States: ACCEPT, CMP_MAX, CMP_MIN, DONE. in_ready=1 only in ACCEPT; out_valid=1 only in DONE.
//  - ACCEPT, handshake, count==0: max=min=in_data, both idx=0, count=1;
//      -> DONE if in_last else stay ACCEPT.
//  - ACCEPT, handshake, count>0: latch in_data+position to hold reg, count++ -> CMP_MAX.
//  - CMP_MAX: comparator a=hold, b=max_val; y1 -> max_val=hold, max_idx=hold pos. -> CMP_MIN.
//  - CMP_MIN: comparator a=hold, b=min_val; y3 -> min_val=hold, min_idx=hold pos.
//      -> DONE if held sample had in_last or count==DEPTH (set ovf only if not in_last); else ACCEPT.
//  - Ties (y2): tracker unchanged; first occurrence wins.
//  - Throughput: 1 sample/3 cycles after the first; latency last-accept -> out_valid = 2 cycles
//      (1 cycle if burst is a single sample).
//  - DONE: all result outputs registered and stable while out_valid&!out_ready;
//      on out_ready: clear trackers, count, ovf -> ACCEPT next cycle (in_ready=1 that cycle).
//  - DEPTH wrap: count never exceeds DEPTH; sample DEPTH+1 is never accepted into same burst.
//  - in_valid ignored outside ACCEPT; in_data/in_last need only be valid at handshake.
//  - rst mid-burst or in DONE: partial burst discarded, reset values next cycle.
//  - Comparator combinational; its inputs muxed by state, outputs sampled same cycle.
// CONFIGURATION
//  - COMPAR_SEQ_DUAL_EN defined: second compar3bit instance; CMP_MAX compares hold vs max and
//    hold vs min in the same cycle, CMP_MIN state removed; 1 sample/2 cycles, latency 1 cycle.
//  - Undefined: single shared comparator, behaviour as above. Results identical in both builds.
// TESTING
//  1. Burst 3,6,1,6,0(last) -> max=6 idx=1, min=0 idx=4, count=5, eq_all=0, ovf=0.
//  2. Single sample 5 with last -> out_valid 1 cycle later; max=min=5, idx=0, count=1, eq_all=1.
//  3. 8 samples 2,2,..,7 (DEPTH=8), no last -> ovf=1, count=8, max=7 idx=7, min=2 idx=0;
//     in_ready stays 0 until result consumed.
//  4. out_ready low 10 cycles in DONE -> all outputs stable, in_ready=0; out_ready=1 -> next
//     cycle out_valid=0, in_ready=1, count=0.
//  5. rst asserted during CMP_MAX of burst 4,1 -> next cycle all outputs 0, in_ready=1; new
//     burst 7(last) -> max=min=7.
//  6. Back-to-back in_valid, burst 0..4 -> accept spacing 3 cycles (2 with
//     COMPAR_SEQ_DUAL_EN); max=4 idx=4, min=0 idx=0 in both builds.

Source files
------------

// File: rtl/compar_minmax_seq.sv
// compar_minmax_seq: accepts bursts of 3-bit samples and tracks the running
// maximum/minimum (with first-occurrence positions) using a time-multiplexed
// compar3bit comparator. One result per burst is presented over valid/ready.
//
// Optional build macro COMPAR_SEQ_DUAL_EN: adds a second comparator so the
// max and min updates happen in the same cycle (CMP_MIN state unused).
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid && ready are both high; valid-side payload only needs to be
// correct in that cycle, and ready never depends combinationally on valid.

module compar3bit (
  input  logic [2:0] a,
  input  logic [2:0] b,
  output logic       y1,
  output logic       y2,
  output logic       y3
);
  assign y1 = (a > b);
  assign y2 = (a == b);
  assign y3 = (a < b);
endmodule

module compar_minmax_seq #(
  parameter int DEPTH = 8,
  parameter int IW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2:0]    max_val,
  output logic [2:0]    min_val,
  output logic [IW-1:0] max_idx,
  output logic [IW-1:0] min_idx,
  output logic [CW-1:0] count,
  output logic          eq_all,
  output logic          ovf,
  output logic [1:0]    dbg_state_o
);

  typedef enum logic [1:0] {
    ACCEPT  = 2'd0,
    CMP_MAX = 2'd1,
    CMP_MIN = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_t        state_q, state_d;
  logic [2:0]    max_q, max_d;
  logic [2:0]    min_q, min_d;
  logic [IW-1:0] max_idx_q, max_idx_d;
  logic [IW-1:0] min_idx_q, min_idx_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [2:0]    hold_val_q, hold_val_d;
  logic [IW-1:0] hold_idx_q, hold_idx_d;
  logic          hold_last_q, hold_last_d;

  logic          accept;
  logic          burst_end;
  logic [2:0]    cmp_b;
  logic          cmp_gt, cmp_eq, cmp_lt;
  logic          unused_cmp;

  assign accept    = (state_q == ACCEPT) && in_valid;
  // Burst closes on the held sample's last flag or when DEPTH samples are in.
  assign burst_end = hold_last_q || (count_q == DEPTH_C);

  // Shared comparator: the held sample against max in CMP_MAX, min in CMP_MIN.
  assign cmp_b = (state_q == CMP_MIN) ? min_q : max_q;

  compar3bit u_cmp (
    .a  (hold_val_q),
    .b  (cmp_b),
    .y1 (cmp_gt),
    .y2 (cmp_eq),
    .y3 (cmp_lt)
  );

`ifdef COMPAR_SEQ_DUAL_EN
  logic cmp2_gt, cmp2_eq, cmp2_lt;

  compar3bit u_cmp_min (
    .a  (hold_val_q),
    .b  (min_q),
    .y1 (cmp2_gt),
    .y2 (cmp2_eq),
    .y3 (cmp2_lt)
  );

  // Equality outputs are not needed: on a tie the tracker simply holds.
  assign unused_cmp = cmp_eq ^ cmp2_eq ^ cmp2_gt;
`else
  // Equality output is not needed: on a tie the tracker simply holds.
  assign unused_cmp = cmp_eq;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ACCEPT;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCEPT: begin
        if (accept) begin
          if (count_q == '0) state_d = in_last ? DONE : ACCEPT;
          else               state_d = CMP_MAX;
        end
      end
`ifdef COMPAR_SEQ_DUAL_EN
      CMP_MAX: state_d = burst_end ? DONE : ACCEPT;
`else
      CMP_MAX: state_d = CMP_MIN;
      CMP_MIN: state_d = burst_end ? DONE : ACCEPT;
`endif
      DONE:    if (out_ready) state_d = ACCEPT;
      default: state_d = ACCEPT;
    endcase
  end

  // Output decode from state.
  always_comb begin
    in_ready    = (state_q == ACCEPT);
    out_valid   = (state_q == DONE);
    dbg_state_o = state_q;
  end

  // Datapath next-state: trackers, burst counter, hold register, overflow flag.
  always_comb begin
    max_d       = max_q;
    min_d       = min_q;
    max_idx_d   = max_idx_q;
    min_idx_d   = min_idx_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    hold_val_d  = hold_val_q;
    hold_idx_d  = hold_idx_q;
    hold_last_d = hold_last_q;
    case (state_q)
      ACCEPT: begin
        if (accept) begin
          if (count_q == '0) begin
            // First sample seeds both trackers directly.
            max_d     = in_data;
            min_d     = in_data;
            max_idx_d = '0;
            min_idx_d = '0;
            count_d   = CW'(1);
          end else begin
            hold_val_d  = in_data;
            hold_idx_d  = count_q[IW-1:0];
            hold_last_d = in_last;
            count_d     = count_q + CW'(1);
          end
        end
      end
      CMP_MAX: begin
        if (cmp_gt) begin
          max_d     = hold_val_q;
          max_idx_d = hold_idx_q;
        end
`ifdef COMPAR_SEQ_DUAL_EN
        if (cmp2_lt) begin
          min_d     = hold_val_q;
          min_idx_d = hold_idx_q;
        end
        if (burst_end && !hold_last_q) ovf_d = 1'b1;
`endif
      end
      CMP_MIN: begin
        if (cmp_lt) begin
          min_d     = hold_val_q;
          min_idx_d = hold_idx_q;
        end
        if (burst_end && !hold_last_q) ovf_d = 1'b1;
      end
      DONE: begin
        if (out_ready) begin
          max_d       = '0;
          min_d       = '0;
          max_idx_d   = '0;
          min_idx_d   = '0;
          count_d     = '0;
          ovf_d       = 1'b0;
          hold_val_d  = '0;
          hold_idx_d  = '0;
          hold_last_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      max_q       <= '0;
      min_q       <= '0;
      max_idx_q   <= '0;
      min_idx_q   <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      hold_val_q  <= '0;
      hold_idx_q  <= '0;
      hold_last_q <= 1'b0;
    end else begin
      max_q       <= max_d;
      min_q       <= min_d;
      max_idx_q   <= max_idx_d;
      min_idx_q   <= min_idx_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      hold_val_q  <= hold_val_d;
      hold_idx_q  <= hold_idx_d;
      hold_last_q <= hold_last_d;
    end
  end

  assign max_val = max_q;
  assign min_val = min_q;
  assign max_idx = max_idx_q;
  assign min_idx = min_idx_q;
  assign count   = count_q;
  assign ovf     = ovf_q;
  // Gated by count so an empty (reset/cleared) tracker does not read as equal.
  assign eq_all  = (count_q != '0) && (max_q == min_q);

endmodule

// File: tb/tb_compar_minmax_seq.sv
// Directed bench for compar_minmax_seq (DEPTH=8). Works for both the default
// and the COMPAR_SEQ_DUAL_EN build; timing expectations switch on the macro.
`timescale 1ns/1ps

module tb_compar_minmax_seq;

  localparam int DEPTH = 8;
  localparam int IW    = 3;
  localparam int CW    = 4;
  localparam int RW    = 3 + 3 + IW + IW + CW + 1 + 1;
`ifdef COMPAR_SEQ_DUAL_EN
  localparam int LAT = 1;
  localparam int SP  = 2;
`else
  localparam int LAT = 2;
  localparam int SP  = 3;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_last, out_valid, out_ready;
  logic [2:0]    in_data, max_val, min_val;
  logic [IW-1:0] max_idx, min_idx;
  logic [CW-1:0] count;
  logic          eq_all, ovf;
  logic [1:0]    dbg_state;
  logic [RW-1:0] res;
  logic [RW-1:0] exp_q[$];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  compar_minmax_seq #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .max_val    (max_val),
    .min_val    (min_val),
    .max_idx    (max_idx),
    .min_idx    (min_idx),
    .count      (count),
    .eq_all     (eq_all),
    .ovf        (ovf),
    .dbg_state_o(dbg_state)
  );

  // Result bundle: {max_val, min_val, max_idx, min_idx, count, eq_all, ovf}
  assign res = {max_val, min_val, max_idx, min_idx, count, eq_all, ovf};

  // ---------------- driver tasks (enter and leave on negedge) ----------------
  task automatic send(input logic [2:0] d, input logic l, output longint t_acc);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
      t_acc = -1;
    end else begin
      @(posedge clk);
      t_acc = $time;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!out_valid) begin
      failures++;
      $display("FAIL out_timeout: out_valid=%0b after %0d cycles, required 1", out_valid, n);
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready, count} !== {1'b0, 1'b1, 4'd0}) begin
      failures++;
      $display("FAIL consume: out_valid=%0b in_ready=%0b count=%0d, required 0 1 0",
               out_valid, in_ready, count);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, res} !== {1'b1, 1'b0, {RW{1'b0}}}) begin
      failures++;
      $display("FAIL reset: in_ready=%0b out_valid=%0b res=%h, required 1 0 0",
               in_ready, out_valid, res);
    end
  endtask

  task automatic test_burst_basic();
    longint t;
    int n;
    exp_q.push_back({3'd6, 3'd0, 3'd1, 3'd4, 4'd5, 1'b0, 1'b0});
    send(3'd3, 1'b0, t);
    send(3'd6, 1'b0, t);
    send(3'd1, 1'b0, t);
    send(3'd6, 1'b0, t);
    send(3'd0, 1'b1, t);
    wait_out(n);
    checks++;
    if (n !== LAT) begin
      failures++;
      $display("FAIL basic_latency: %0d cycles, required %0d", n, LAT);
    end
    checks++;
    if (res !== exp_q[0]) begin
      failures++;
      $display("FAIL basic_result: res=%h, required %h", res, exp_q[0]);
    end
  endtask

  // Runs while the basic burst result is still pending in DONE.
  task automatic test_hold_stable();
    logic [RW-1:0] e;
    e = exp_q.pop_front();
    in_valid = 1'b1;
    in_data  = 3'd7;
    in_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, res} !== {1'b1, 1'b0, e}) begin
        failures++;
        $display("FAIL hold_stable[%0d]: out_valid=%0b in_ready=%0b res=%h, required 1 0 %h",
                 i, out_valid, in_ready, res, e);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    consume();
  endtask

  task automatic test_single();
    longint t;
    int n;
    exp_q.push_back({3'd5, 3'd5, 3'd0, 3'd0, 4'd1, 1'b1, 1'b0});
    send(3'd5, 1'b1, t);
    wait_out(n);
    checks++;
    if (n !== 0) begin
      failures++;
      $display("FAIL single_latency: %0d extra cycles, required 0", n);
    end
    checks++;
    if (res !== exp_q[0]) begin
      failures++;
      $display("FAIL single_result: res=%h, required %h", res, exp_q[0]);
    end
    void'(exp_q.pop_front());
    consume();
  endtask

  task automatic test_ovf();
    longint t;
    int n;
    exp_q.push_back({3'd7, 3'd2, 3'd7, 3'd0, 4'd8, 1'b0, 1'b1});
    for (int i = 0; i < 7; i++) send(3'd2, 1'b0, t);
    send(3'd7, 1'b0, t);
    wait_out(n);
    checks++;
    if (n !== LAT) begin
      failures++;
      $display("FAIL ovf_latency: %0d cycles, required %0d", n, LAT);
    end
    // A ninth sample offered now must not be taken into this burst.
    in_valid = 1'b1;
    in_data  = 3'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL ovf_in_ready[%0d]: in_ready=%0b, required 0", i, in_ready);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (res !== exp_q[0]) begin
      failures++;
      $display("FAIL ovf_result: res=%h, required %h", res, exp_q[0]);
    end
    void'(exp_q.pop_front());
    consume();
  endtask

  task automatic test_rst_mid();
    longint t;
    int n;
    send(3'd4, 1'b0, t);
    send(3'd1, 1'b0, t);
    checks++;
    if (dbg_state !== 2'd1) begin
      failures++;
      $display("FAIL rst_mid_state: state=%0d, required 1", dbg_state);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, res} !== {1'b1, 1'b0, {RW{1'b0}}}) begin
      failures++;
      $display("FAIL rst_mid_clear: in_ready=%0b out_valid=%0b res=%h, required 1 0 0",
               in_ready, out_valid, res);
    end
    exp_q.push_back({3'd7, 3'd7, 3'd0, 3'd0, 4'd1, 1'b1, 1'b0});
    send(3'd7, 1'b1, t);
    wait_out(n);
    checks++;
    if (res !== exp_q[0]) begin
      failures++;
      $display("FAIL rst_mid_result: res=%h, required %h", res, exp_q[0]);
    end
    void'(exp_q.pop_front());
    consume();
  endtask

  task automatic test_back_to_back();
    longint t [5];
    int n;
    exp_q.push_back({3'd4, 3'd0, 3'd4, 3'd0, 4'd5, 1'b0, 1'b0});
    for (int i = 0; i < 5; i++) send(3'(i), (i == 4), t[i]);
    for (int i = 1; i < 5; i++) begin
      checks++;
      // The second sample follows the seeding sample immediately.
      if ((t[i] - t[i-1]) !== longint'(((i == 1) ? 1 : SP) * 10)) begin
        failures++;
        $display("FAIL b2b_spacing[%0d]: %0d ns, required %0d ns",
                 i, t[i] - t[i-1], ((i == 1) ? 1 : SP) * 10);
      end
    end
    wait_out(n);
    checks++;
    if (res !== exp_q[0]) begin
      failures++;
      $display("FAIL b2b_result: res=%h, required %h", res, exp_q[0]);
    end
    void'(exp_q.pop_front());
    consume();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    @(negedge clk);
    test_reset();
    test_burst_basic();
    test_hold_stable();
    test_single();
    test_ovf();
    test_rst_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
